// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
//
// A small multicycle processor core. Every instruction goes through
// FETCH -> DECODE -> EXEC -> WB, taking at least four cycles. The fetch
// waits, with no time limit, for the instruction memory to acknowledge.
// Opcode 6'h3F halts the core, and only reset leaves HALT.
//
// Instruction fields:
//   opcode[31:26] rd[25:21] rs1[20:16] rs2[15:11] shamt[10:6] fn[5:0]
//   imm21[20:0] (LI)   off16[15:0] (BZ)
//
// Parameters:
//   XLEN  - datapath and register width (32 or 64)
//   NREGS - register count, a power of two from 8 to 32. The low log2(NREGS)
//           bits of each 5-bit register field form the register index.
//   PC_W  - program counter and instruction address width (at most 32)
//
// Configuration macro:
//   MULTICYCLE_CORE_SHIFT_EN - when defined, R-type fn 00/02/03 execute as
//                              SLL/SRL/SRA by shamt. When undefined there is
//                              no shifter, and those fn codes are illegal.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - level; the core leaves IDLE while it is 1
//   imem_req   - instruction fetch request (high only in FETCH)
//   imem_addr  - fetch address, always equal to pc
//   imem_ack   - fetch data valid this cycle
//   imem_rdata - instruction word
//   pc         - current program counter
//   wb_valid   - one-cycle pulse during the write-back of a writing instruction
//   wb_addr    - register index written, zero-extended to 5 bits
//   wb_data    - value written
//   halted     - core is in HALT
//   illegal    - sticky flag: an undefined opcode or fn was executed
// -----------------------------------------------------------------------------
module multicycle_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            halted,
    output logic            illegal
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LI    = 6'h01;
    localparam logic [5:0] OP_BZ    = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;
`ifdef MULTICYCLE_CORE_SHIFT_EN
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [PC_W-1:0] npc;
    logic [XLEN-1:0] regs [NREGS];

    // Instruction field decode
    logic [5:0]       opcode;
    logic [5:0]       fn;
    logic [4:0]       shamt;
    logic [20:0]      imm21;
    logic [15:0]      off16;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;

    assign opcode  = ir[31:26];
    assign fn      = ir[5:0];
    assign shamt   = ir[10:6];
    assign imm21   = ir[20:0];
    assign off16   = ir[15:0];
    assign rd_idx  = ir[21 +: IDX_W];
    assign rs1_idx = ir[16 +: IDX_W];
    assign rs2_idx = ir[11 +: IDX_W];

    assign imem_addr = pc;

    // The branch offset is sign-extended to 32 bits and then truncated, so
    // the pc addition wraps modulo 2^PC_W for negative offsets.
    logic [31:0]     off_ext;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_branch;

    assign off_ext   = {{16{off16[15]}}, off16};
    assign pc_plus1  = pc + PC_W'(1);
    assign pc_branch = pc + off_ext[PC_W-1:0];

    // Execute stage: this logic combines the latched operands and the IR.
    logic [XLEN-1:0] ex_result;
    logic            ex_write;
    logic            ex_illegal;
    logic            ex_halt;
    logic [PC_W-1:0] ex_npc;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statements can leave a value held and infer a latch.
        ex_result  = '0;
        ex_write   = 1'b0;
        ex_illegal = 1'b0;
        ex_halt    = 1'b0;
        ex_npc     = pc_plus1;
        case (opcode)
            OP_RTYPE: begin
                ex_write = 1'b1;
                case (fn)
                    FN_ADD: ex_result = op_a + op_b;
                    FN_SUB: ex_result = op_a - op_b;
                    FN_AND: ex_result = op_a & op_b;
                    FN_OR:  ex_result = op_a | op_b;
                    FN_XOR: ex_result = op_a ^ op_b;
                    FN_SLT: ex_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef MULTICYCLE_CORE_SHIFT_EN
                    FN_SLL: ex_result = op_a << shamt;
                    FN_SRL: ex_result = op_a >> shamt;
                    FN_SRA: ex_result = $signed(op_a) >>> shamt;
`endif
                    default: begin
                        ex_write   = 1'b0;
                        ex_illegal = 1'b1;
                    end
                endcase
            end
            OP_LI: begin
                ex_write  = 1'b1;
                ex_result = {{(XLEN-21){imm21[20]}}, imm21};
            end
            OP_BZ: begin
                if (op_a == '0) begin
                    ex_npc = pc_branch;
                end
            end
            OP_HALT: ex_halt = 1'b1;
            default: ex_illegal = 1'b1;
        endcase
    end

`ifndef MULTICYCLE_CORE_SHIFT_EN
    // Without the shifter, shamt has no consumer of its own. The same IR bits
    // still feed imm21.
    logic shamt_unused;
    assign shamt_unused = ^shamt;
`endif

    // Register 0 always reads as zero, whatever the array holds.
    function automatic logic [XLEN-1:0] read_reg(input logic [IDX_W-1:0] idx,
                                                 input logic [XLEN-1:0] val);
        return (idx == '0) ? '0 : val;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            npc      <= '0;
            imem_req <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            // NOTE: the register file is cleared by reset, so it is built from
            // flops rather than RAM. This is deliberate: a program may read a
            // register before it writes one.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments. Reads in
            // this block therefore see the values from before the edge, and
            // that keeps read-before-write ordering correct.
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // The operands are latched here. An instruction whose
                    // source is also its destination therefore sees the old
                    // value.
                    op_a  <= read_reg(rs1_idx, regs[rs1_idx]);
                    op_b  <= read_reg(rs2_idx, regs[rs2_idx]);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ex_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        if (ex_write) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= 5'(rd_idx);
                            wb_data  <= ex_result;
                        end
                        if (ex_illegal) begin
                            illegal <= 1'b1;
                        end
                        npc   <= ex_npc;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    // wb_valid is high for exactly this cycle. A write to
                    // register 0 still pulses wb_valid but does not change
                    // the array.
                    if (wb_valid && (rd_idx != '0)) begin
                        regs[rd_idx] <= wb_data;
                    end
                    pc       <= npc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_core
//
// Testbench for multicycle_core. Each directed program is loaded into a
// behavioural instruction memory. The write-backs the program should produce
// are queued as it is loaded. A monitor pops the queue on every wb_valid pulse
// and compares the write-back. A responder answers fetches after a chosen
// delay and checks that each fetch burst is well formed. The main sequence
// checks the reset state, the final pc, the flags and that HALT absorbs.
// -----------------------------------------------------------------------------
module tb_multicycle_core;

    localparam int XLEN = 32;
    localparam int PC_W = 8;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic [PC_W-1:0] pc;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            halted;
    logic            illegal;

    multicycle_core #(.XLEN(XLEN), .NREGS(32), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          wb_cyc[$];
    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    bit          late_ack = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] li(input int rd, input int imm);
        return {6'h01, 5'(rd), 21'(imm)};
    endfunction

    function automatic logic [31:0] bz(input int rs1, input int off);
        return {6'h02, 5'd0, 5'(rs1), 16'(off)};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] fn, input int rd,
                                       input int rs1, input int rs2, input int sh);
        return {6'h00, 5'(rd), 5'(rs1), 5'(rs2), 5'(sh), fn};
    endfunction

    task automatic push(input int addr, input logic [XLEN-1:0] data);
        wb_exp_t e;
        e.addr = 5'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each write-back must match the oldest expected one.
    always @(negedge clk) begin
        wb_exp_t e;
        if (rst_n && wb_valid) begin
            wb_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check(1'b0, "wb_unexpected", {27'd0, wb_addr, wb_data}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(wb_addr == e.addr && wb_data == e.data, "wb_match",
                      {27'd0, wb_addr, wb_data}, {27'd0, e.addr, e.data});
            end
        end
    end

    // Instruction memory responder. It acknowledges on the (ack_delay+1)-th
    // cycle of a request. A burst must keep imem_addr steady and equal to pc,
    // and the request must drop right after the acknowledge.
    int          run = 0;
    logic [PC_W-1:0] run_addr = '0;
    always @(negedge clk) begin
        if (late_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = li(9, 9);
            run        = 0;
        end else if (!rst_n) begin
            imem_ack = 1'b0;
            run      = 0;
        end else if (imem_req) begin
            if (run == 0) begin
                run_addr = imem_addr;
                check(imem_addr == pc, "fetch_addr_is_pc", 64'(imem_addr), 64'(pc));
            end else if (imem_addr != run_addr) begin
                check(1'b0, "fetch_addr_stable", 64'(imem_addr), 64'(run_addr));
            end
            run++;
            if (run == ack_delay + 1) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack = 1'b0;
            end
        end else begin
            if (run > 0) check(run == ack_delay + 1, "fetch_req_len", 64'(run), 64'(ack_delay + 1));
            run      = 0;
            imem_ack = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check(pc == '0 && !imem_req && !wb_valid && wb_addr == '0 && !halted && !illegal,
              "reset_state", {pc, wb_addr, wb_valid, imem_req, halted, illegal}, 64'd0);
        check(wb_data == '0, "reset_wb_data", 64'(wb_data), 64'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        wb_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int exp_pc, input bit exp_ill, input int exp_gap);
        int n;
        int reqs;
        logic [PC_W-1:0] pc_s;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(halted, "halt_reached", 64'(halted), 64'd1);
        check(exp_q.size() == 0, "wb_all_seen", 64'(exp_q.size()), 64'd0);
        check(pc == PC_W'(exp_pc), "final_pc", 64'(pc), 64'(exp_pc));
        check(illegal == exp_ill, "illegal_flag", 64'(illegal), 64'(exp_ill));
        if (exp_gap > 0) begin
            if (wb_cyc.size() >= 2)
                check(wb_cyc[1] - wb_cyc[0] == exp_gap, "instr_cycles",
                      64'(wb_cyc[1] - wb_cyc[0]), 64'(exp_gap));
            else
                check(1'b0, "instr_cycles", 64'(wb_cyc.size()), 64'd2);
        end
        pc_s = pc;
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        check(reqs == 0 && pc == pc_s && halted, "halt_absorbing",
              {48'(reqs), pc, 7'd0, halted}, {48'd0, pc_s, 8'd1});
    endtask

    initial begin
        int n;
        // Watchdog: report and stop if the run never reaches its end.
        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Program 1: LI, ALU ops, writes to r0, same-register read, illegal op.
        do_reset();
        clear_mem();
        mem[0]  = li(1, 5);                 push(1, 32'd5);
        mem[1]  = li(2, -3);                push(2, 32'hFFFF_FFFD);
        mem[2]  = rr(FN_ADD, 3, 1, 2, 0);   push(3, 32'd2);
        mem[3]  = li(0, 7);                 push(0, 32'd7);
        mem[4]  = rr(FN_ADD, 5, 0, 0, 0);   push(5, 32'd0);
        mem[5]  = rr(FN_SUB, 6, 1, 2, 0);   push(6, 32'd8);
        mem[6]  = rr(FN_AND, 7, 1, 2, 0);   push(7, 32'd5);
        mem[7]  = rr(FN_OR, 8, 1, 2, 0);    push(8, 32'hFFFF_FFFD);
        mem[8]  = rr(FN_XOR, 9, 1, 2, 0);   push(9, 32'hFFFF_FFF8);
        mem[9]  = rr(FN_SLT, 10, 2, 1, 0);  push(10, 32'd1);
        mem[10] = rr(FN_SLT, 11, 1, 2, 0);  push(11, 32'd0);
        mem[11] = rr(FN_ADD, 1, 1, 1, 0);   push(1, 32'd10);
        mem[12] = {6'h15, 26'd0};
        mem[13] = li(12, 1);                push(12, 32'd1);
        mem[14] = rr(FN_SUB, 13, 0, 12, 0); push(13, 32'hFFFF_FFFF);
        run_prog(15, 1'b1, 4);

        // Program 2: branches taken both ways; fetches acknowledged on their third cycle.
        do_reset();
        clear_mem();
        ack_delay = 2;
        mem[0]  = li(4, 0);   push(4, 32'd0);
        mem[1]  = li(5, 1);   push(5, 32'd1);
        mem[2]  = bz(4, 8);
        mem[10] = bz(4, -2);
        mem[8]  = li(4, 1);   push(4, 32'd1);
        mem[9]  = li(6, 6);   push(6, 32'd6);
        run_prog(11, 1'b0, 6);
        ack_delay = 0;

        // Program 3: backward branch at pc 0 wraps to 255; pc+1 wraps to 0.
        do_reset();
        clear_mem();
        mem[0]   = bz(7, -1);
        mem[255] = li(7, 3);  push(7, 32'd3);
        run_prog(1, 1'b0, 0);

        // Program 4: reset during FETCH; a late ack is ignored; registers are cleared.
        do_reset();
        clear_mem();
        ack_delay = 4;
        mem[0] = rr(FN_ADD, 3, 1, 0, 0);  push(3, 32'd0);
        mem[1] = li(1, 5);                push(1, 32'd5);
        mem[2] = li(2, 7);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(pc == PC_W'(2) && imem_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(pc == PC_W'(2) && imem_req, "reached_fetch_pc2", {pc, 7'd0, imem_req}, {8'd2, 8'd1});
        #2;
        rst_n = 1'b0;
        #1;
        check(!imem_req && pc == '0, "reset_drops_req", {pc, 7'd0, imem_req}, 64'd0);
        check(exp_q.size() == 0, "wb_before_reset", 64'(exp_q.size()), 64'd0);
        late_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check(!imem_req && pc == '0 && !wb_valid, "idle_ignores_ack",
              {pc, 6'd0, wb_valid, imem_req}, 64'd0);
        late_ack = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        push(3, 32'd0);
        push(1, 32'd5);
        push(2, 32'd7);
        run_prog(3, 1'b0, 0);

        // Program 5: shifts (illegal when the shifter is not built in).
        do_reset();
        clear_mem();
        mem[0] = li(1, -1);                push(1, 32'hFFFF_FFFF);
        mem[1] = rr(FN_SLL, 2, 1, 0, 31);
        mem[2] = rr(FN_SRA, 3, 2, 0, 4);
        mem[3] = rr(FN_SRL, 4, 2, 0, 4);
`ifdef MULTICYCLE_CORE_SHIFT_EN
        push(2, 32'h8000_0000);
        push(3, 32'hF800_0000);
        push(4, 32'h0800_0000);
        run_prog(4, 1'b0, 0);
`else
        run_prog(4, 1'b1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
